// File: rtl/serial_word_port_pkg.sv
// serial_word_port_pkg
// Shared definitions for the parallel<->bit-serial word port and the serial ALU
// stages it feeds: the port state encoding, the default word width and a helper
// giving the number of SHIFT cycles per word.
//
// Optional feature macro: SERIAL_WORD_PORT_SKEW_EN (downstream serial stage has a
// registered output, so capture trails ser_out by one cycle).
package serial_word_port_pkg;

    // Default word width, shared with the serial incrementer and similar stages.
    localparam int SWP_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } swp_state_e;

    // Number of cycles spent in SHIFT for one word.
    function automatic int swp_shift_len(input int width);
`ifdef SERIAL_WORD_PORT_SKEW_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

endpackage

// File: rtl/serial_word_port_if.sv
// serial_word_port_if
// Bundles the three handshakes of the word port:
//   load_*   : parallel operand in (valid/ready/data)
//   ser_*    : bit-serial operand out (ser_out/ser_first/ser_active), result in (ser_in)
//   result_* : parallel result out (valid/ready/data)
// Modports:
//   slave  - the port itself (serial_word_port)
//   master - the surrounding environment (operand producer, serial stage, consumer)
interface serial_word_port_if
    import serial_word_port_pkg::*;
#(
    parameter int WIDTH = SWP_DEFAULT_WIDTH
);

    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic             ser_out;
    logic             ser_first;
    logic             ser_active;
    logic             ser_in;
    logic             result_valid;
    logic             result_ready;
    logic [WIDTH-1:0] result_data;

    modport slave (
        input  load_valid, load_data, ser_in, result_ready,
        output load_ready, ser_out, ser_first, ser_active, result_valid, result_data
    );

    modport master (
        output load_valid, load_data, ser_in, result_ready,
        input  load_ready, ser_out, ser_first, ser_active, result_valid, result_data
    );

endinterface

// File: rtl/serial_word_port_fsm.sv
// serial_word_port_fsm
// Control for the word port: IDLE -> SHIFT -> HOLD state machine, the bit
// counter and the registered handshake/serial strobes.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   load_valid        operand offered (only honoured in IDLE)
//   result_ready      consumer accepts the held result
//   load_ready        registered, high in IDLE
//   ser_first         registered, high while bit 0 is on ser_out
//   ser_active        registered, high in SHIFT
//   result_valid      registered, high in HOLD
//   load_fire         comb strobe: operand accepted this cycle
//   shift_en          comb strobe: shift register advances this cycle
//   cap_en            comb strobe: ser_in is captured this cycle
//   last_bit          comb strobe: final capture of the word this cycle
// Optional feature macro: SERIAL_WORD_PORT_SKEW_EN.
module serial_word_port_fsm
    import serial_word_port_pkg::*;
#(
    parameter int WIDTH = SWP_DEFAULT_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic load_valid,
    input  logic result_ready,
    output logic load_ready,
    output logic ser_first,
    output logic ser_active,
    output logic result_valid,
    output logic load_fire,
    output logic shift_en,
    output logic cap_en,
    output logic last_bit
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    // Counter value of the final SHIFT cycle; the counter parks here rather than
    // advancing past it, so it never wraps for any WIDTH.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(swp_shift_len(WIDTH) - 1);

    swp_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_ready_q, load_ready_d;
    logic             ser_first_q, ser_first_d;
    logic             ser_active_q, ser_active_d;
    logic             result_valid_q, result_valid_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        load_fire = 1'b0;
        shift_en  = 1'b0;
        cap_en    = 1'b0;
        last_bit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_valid) begin
                    load_fire = 1'b1;
                    cnt_d     = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
`ifdef SERIAL_WORD_PORT_SKEW_EN
                // Registered downstream stage: nothing valid on ser_in yet in the
                // cycle bit 0 is presented.
                cap_en = (cnt_q != '0);
`else
                cap_en = 1'b1;
`endif
                if (cnt_q == LAST_CNT) begin
                    last_bit = 1'b1;
                    state_d  = HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                if (result_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Strobes are registered from the next state so they line up with it.
        load_ready_d   = (state_d == IDLE);
        ser_active_d   = (state_d == SHIFT);
        ser_first_d    = (state_d == SHIFT) && (cnt_d == '0);
        result_valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            load_ready_q   <= 1'b1;
            ser_first_q    <= 1'b0;
            ser_active_q   <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            load_ready_q   <= load_ready_d;
            ser_first_q    <= ser_first_d;
            ser_active_q   <= ser_active_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign load_ready   = load_ready_q;
    assign ser_first    = ser_first_q;
    assign ser_active   = ser_active_q;
    assign result_valid = result_valid_q;

endmodule

// File: rtl/serial_word_port.sv
// serial_word_port
// Parallel<->bit-serial adapter around the serial ALU stages. A parallel operand
// is shifted out LSB-first on ser_out, one bit per clock, while the serial
// stage's result is shifted in LSB-first from ser_in and returned as a word.
// Ports:
//   clk   system clock (rising edge)
//   rst   synchronous, active-high reset
//   bus   serial_word_port_if.slave: load_* handshake, ser_out/ser_first/
//         ser_active/ser_in serial link, result_* handshake
// Optional feature macro: SERIAL_WORD_PORT_SKEW_EN (one cycle of skew between
// ser_out and the returned ser_in bit).
module serial_word_port
    import serial_word_port_pkg::*;
#(
    parameter int WIDTH = SWP_DEFAULT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_word_port_if.slave     bus
);

    logic             load_fire;
    logic             shift_en;
    logic             cap_en;
    logic             last_bit;
    logic             load_ready;
    logic             ser_first;
    logic             ser_active;
    logic             result_valid;

    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [WIDTH-1:0] res_q, res_d;

    serial_word_port_fsm #(
        .WIDTH (WIDTH)
    ) u_fsm (
        .clk          (clk),
        .rst          (rst),
        .load_valid   (bus.load_valid),
        .result_ready (bus.result_ready),
        .load_ready   (load_ready),
        .ser_first    (ser_first),
        .ser_active   (ser_active),
        .result_valid (result_valid),
        .load_fire    (load_fire),
        .shift_en     (shift_en),
        .cap_en       (cap_en),
        .last_bit     (last_bit)
    );

    always_comb begin
        shift_d = shift_q;
        cap_d   = cap_q;
        res_d   = res_q;
        if (load_fire) begin
            shift_d = bus.load_data;
        end else if (shift_en) begin
            shift_d = shift_q >> 1;
        end
        if (cap_en) begin
            cap_d = {bus.ser_in, cap_q[WIDTH-1:1]};
        end
        // The result word is frozen separately so result_data keeps the last
        // completed word while the next one is being assembled in cap_q.
        if (last_bit) begin
            res_d = cap_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
            cap_q   <= '0;
            res_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cap_q   <= cap_d;
            res_q   <= res_d;
        end
    end

    // Gated with ser_active so ser_out is 0 outside SHIFT even if the shift
    // register were left non-zero (e.g. in the extra skew cycle it is already 0).
    assign bus.ser_out      = shift_q[0] & ser_active;
    assign bus.ser_first    = ser_first;
    assign bus.ser_active   = ser_active;
    assign bus.load_ready   = load_ready;
    assign bus.result_valid = result_valid;
    assign bus.result_data  = res_q;

endmodule

// File: tb/tb_serial_word_port.sv
// tb_serial_word_port
// Directed plus randomized bench for serial_word_port. The serial stage on the
// far side of the link is modelled here as either a wire loopback or a serial
// incrementer (carry seeded by ser_first); with SERIAL_WORD_PORT_SKEW_EN the
// stage output is registered. Expected words come from plain arithmetic.
module tb_serial_word_port;
    import serial_word_port_pkg::*;

    localparam int W = 8;
`ifdef SERIAL_WORD_PORT_SKEW_EN
    localparam int SHIFT_LEN = W + 1;
`else
    localparam int SHIFT_LEN = W;
`endif
    localparam int LAT = SHIFT_LEN + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_word_port_if #(.WIDTH(W)) bus ();

    serial_word_port #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Serial stage model: inc_mode=0 loopback, inc_mode=1 serial +1.
    bit   inc_mode;
    logic carry_q;
    logic stage_q;
    logic c_in;
    logic stage_bit;

    always_comb begin
        c_in      = bus.ser_first ? 1'b1 : carry_q;
        stage_bit = inc_mode ? (bus.ser_out ^ c_in) : bus.ser_out;
    end

    always_ff @(posedge clk) begin
        carry_q <= bus.ser_out & c_in;
        stage_q <= stage_bit;
    end

`ifdef SERIAL_WORD_PORT_SKEW_EN
    assign bus.ser_in = stage_q;
`else
    assign bus.ser_in = stage_bit;
`endif

    logic [W-1:0] last_result;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full word: load, watch every SHIFT cycle, then optionally stall the
    // result for 'hold' cycles (with a stray load pulse) before releasing it.
    task automatic run_word(input logic [W-1:0] data, input bit inc, input int hold);
        logic [W-1:0] exp_res;
        int           edges;
        int           idx;
        logic         exp_bit;
        inc_mode = inc;
        exp_res  = inc ? W'(data + W'(1)) : data;

        check("load_ready_idle", 32'(bus.load_ready), 32'd1);
        bus.load_valid = 1'b1;
        bus.load_data  = data;
        tick();
        bus.load_valid = 1'b0;
        bus.load_data  = W'($urandom);

        edges = 1;
        while (bus.result_valid !== 1'b1 && edges < LAT + 4) begin
            idx = edges - 1;
            exp_bit = 1'b0;
            if (idx < W) exp_bit = data[idx];
            check("ser_active", 32'(bus.ser_active), 32'(idx < SHIFT_LEN));
            check("ser_first", 32'(bus.ser_first), 32'(idx == 0));
            check("ser_out", 32'(bus.ser_out), 32'(exp_bit));
            check("load_ready_busy", 32'(bus.load_ready), 32'd0);
            check("result_data_kept", 32'(bus.result_data), 32'(last_result));
            tick();
            edges++;
        end

        check("latency_edges", 32'(edges), 32'(LAT));
        check("result_valid", 32'(bus.result_valid), 32'd1);
        check("result_data", 32'(bus.result_data), 32'(exp_res));
        check("ser_active_hold", 32'(bus.ser_active), 32'd0);
        check("ser_out_hold", 32'(bus.ser_out), 32'd0);

        if (hold > 0) begin
            bus.result_ready = 1'b0;
            for (int h = 0; h < hold; h++) begin
                bus.load_valid = (h == 1);
                bus.load_data  = W'(8'h11);
                tick();
                bus.load_valid = 1'b0;
                check("hold_valid", 32'(bus.result_valid), 32'd1);
                check("hold_data", 32'(bus.result_data), 32'(exp_res));
                check("hold_load_ready", 32'(bus.load_ready), 32'd0);
                check("hold_ser_active", 32'(bus.ser_active), 32'd0);
            end
            bus.result_ready = 1'b1;
        end

        tick();
        check("release_valid", 32'(bus.result_valid), 32'd0);
        check("release_load_ready", 32'(bus.load_ready), 32'd1);
        check("release_ser_active", 32'(bus.ser_active), 32'd0);
        check("release_data", 32'(bus.result_data), 32'(exp_res));
        last_result = exp_res;
    endtask

    initial begin
        rst              = 1'b1;
        inc_mode         = 1'b0;
        bus.load_valid   = 1'b0;
        bus.load_data    = '0;
        bus.result_ready = 1'b1;
        last_result      = '0;
        tick();
        tick();

        // Reset state
        check("rst_load_ready", 32'(bus.load_ready), 32'd1);
        check("rst_ser_out", 32'(bus.ser_out), 32'd0);
        check("rst_ser_first", 32'(bus.ser_first), 32'd0);
        check("rst_ser_active", 32'(bus.ser_active), 32'd0);
        check("rst_result_valid", 32'(bus.result_valid), 32'd0);
        check("rst_result_data", 32'(bus.result_data), 32'd0);
        rst = 1'b0;
        tick();
        check("idle_load_ready", 32'(bus.load_ready), 32'd1);

        // Directed words
        run_word(8'h5A, 1'b0, 0);
        run_word(8'hC3, 1'b0, 0);
        run_word(8'hFF, 1'b1, 0);
        run_word(8'h7F, 1'b1, 0);
        run_word(8'h3C, 1'b0, 5);

        // Reset in the middle of SHIFT (counter at 3)
        inc_mode       = 1'b0;
        bus.load_valid = 1'b1;
        bus.load_data  = 8'h3C;
        tick();
        bus.load_valid = 1'b0;
        tick();
        tick();
        tick();
        check("mid_ser_active", 32'(bus.ser_active), 32'd1);
        check("mid_ser_out", 32'(bus.ser_out), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_load_ready", 32'(bus.load_ready), 32'd1);
        check("abort_ser_out", 32'(bus.ser_out), 32'd0);
        check("abort_ser_active", 32'(bus.ser_active), 32'd0);
        check("abort_result_valid", 32'(bus.result_valid), 32'd0);
        check("abort_result_data", 32'(bus.result_data), 32'd0);
        last_result = '0;
        run_word(8'h01, 1'b0, 0);
        run_word(8'hA5, 1'b0, 0);

        // Randomized words, stage type and backpressure
        for (int n = 0; n < 10; n++) begin
            run_word(W'($urandom_range(0, 255)), bit'($urandom_range(0, 1)),
                     int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
